stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter MAX_MIN, default 59: highest minute value before wrap to 0.
REQ-002 Parameter MAX_SEC, default 59: highest second value before wrap to 0.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 tick_1hz  in  1  one-cycle enable pulse, 1 Hz count rate.
REQ-006 tick_2hz  in  1  one-cycle enable pulse, 2 Hz adjust/blink rate.
REQ-007 pause_p  in  1  one-cycle pulse from an upstream debouncer; toggles run/pause.
REQ-008 clear_p  in  1  one-cycle pulse from an upstream debouncer; zeroes the count.
REQ-009 adj  in  1  level; 1 selects adjust mode.
REQ-010 sel  in  1  level; in adjust mode, 0 selects seconds, 1 selects minutes.
REQ-011 min  out  6  registered minute value, 0..MAX_MIN, feeds the display min input.
REQ-012 sec  out  6  registered second value, 0..MAX_SEC, feeds the display sec input.
REQ-013 blank_min  out  1  1 blanks the minute digits (blink).
REQ-014 blank_sec  out  1  1 blanks the second digits (blink).
REQ-015 running  out  1  1 when the state is RUN.

Function
REQ-016 The block SHALL implement three states: RUN, PAUSE and ADJUST.
REQ-017 The block SHALL move from PAUSE to RUN, and from RUN to PAUSE, on pause_p when adj=0.
REQ-018 The block SHALL enter ADJUST on the cycle after adj is sampled 1, from any state, and SHALL ignore pause_p while in ADJUST.
REQ-019 The block SHALL leave ADJUST for PAUSE on the cycle after adj is sampled 0.
REQ-020 In RUN, each tick_1hz SHALL increment sec; counters SHALL update on the edge that samples the tick (1-cycle latency to outputs).
REQ-021 sec=MAX_SEC with tick_1hz SHALL give sec=0 and min+1 on the same edge.
REQ-022 min=MAX_MIN and sec=MAX_SEC with tick_1hz SHALL give min=0 and sec=0.
REQ-023 In PAUSE, tick_1hz SHALL be ignored.
REQ-024 In ADJUST, each tick_2hz SHALL increment only the selected field, wrap MAX->0, with no carry into the other field; tick_1hz SHALL be ignored.
REQ-025 In ADJUST, a blink phase flag SHALL toggle on each tick_2hz, and the selected field's blank output SHALL equal that flag.
REQ-026 The unselected field's blank output SHALL be 0.
REQ-027 The blink phase flag SHALL be forced to 0 (visible) on entry to ADJUST and whenever sel changes.
REQ-028 Outside ADJUST, blank_min and blank_sec SHALL both be 0.
REQ-029 clear_p SHALL set min=0 and sec=0 on the next edge in any state, with priority over any coincident tick; the state SHALL be unchanged.
REQ-030 A pause_p coinciding with tick_1hz in RUN SHALL apply the tick, then enter PAUSE.
REQ-031 min and sec SHALL never leave 0..MAX; an out-of-range value SHALL wrap to 0 on the next increment.
REQ-032 running SHALL be a registered decode of the state, with no combinational path from inputs.

Reset
REQ-033 rst_n=0 SHALL immediately force: state PAUSE; min=0; sec=0; blink phase 0; blank_min=0; blank_sec=0; running=0.
REQ-034 Reset asserted mid-count or mid-adjust SHALL discard all progress, with no pending tick or pulse honoured after release.
REQ-035 After rst_n rises, the first edge SHALL evaluate inputs normally.

Structure
REQ-036 The state encoding and the default MAX constants SHALL live in the shared package stopwatch_pkg.
REQ-037 A sub-module mod_counter SHALL be instantiated twice (sec, min).
REQ-038 mod_counter SHALL have: parameter MAX; ports clk, rst_n, clr, inc, value[5:0], wrap; wrap=1 when inc is applied at value=MAX.
REQ-039 The top level SHALL contain the FSM, carry gating and the blink flag only.

Verification
REQ-040 Reset, pause_p, then 75 tick_1hz -> min=1, sec=15, running=1.
REQ-041 Preload 59:59 in RUN, one tick_1hz -> 00:00 on the next cycle.
REQ-042 RUN at 00:10, pause_p and tick_1hz in the same cycle -> 00:11 and running=0; 5 further ticks -> still 00:11.
REQ-043 adj=1, sel=0 at 00:58, 3 tick_2hz -> sec sequence 59, 0, 1, min stays 0, blank_sec sequence 1, 0, 1, blank_min=0.
REQ-044 adj=1, sel=1; set sel=0 mid-blink -> blank_sec=0 at the switch; adj=0 -> PAUSE with both blanks 0.
REQ-045 RUN at 12:34, clear_p coincident with tick_1hz -> 00:00, running stays 1; rst_n pulsed low mid-run -> 00:00 immediately, PAUSE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: controller state
// encoding, counter width and the default wrap limits for minutes/seconds.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

  localparam int unsigned CNT_W       = 6;
  localparam int unsigned DEF_MAX_MIN = 59;
  localparam int unsigned DEF_MAX_SEC = 59;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up counter used for the seconds and minutes fields.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears value
//   clr   : synchronous clear, has priority over inc
//   inc   : advance by one; MAX (or any out-of-range value) goes to 0
//   value : current count, 0..MAX
//   wrap  : 1 when inc is applied while value == MAX (carry out)
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  assign wrap = inc && (value == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      // >= rather than == so a corrupted value recovers on its next step
      value <= (value >= MAX_V) ? '0 : value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: RUN / PAUSE / ADJUST state machine, carry gating
// between the seconds and minutes counters, and the adjust-mode blink flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick_1hz, tick_2hz  : single-cycle count / adjust-blink enables
//   pause_p, clear_p    : single-cycle debounced button pulses
//   adj, sel            : adjust mode level, field select (0 sec, 1 min)
//   min, sec            : registered count values
//   blank_min/blank_sec : blank the corresponding digits while blinking
//   running             : registered, 1 in RUN
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN = DEF_MAX_MIN,
  parameter int unsigned MAX_SEC = DEF_MAX_SEC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_p,
  input  logic       clear_p,
  input  logic       adj,
  input  logic       sel,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running
);

  sw_state_e state_q, state_d;
  logic      blink_q, blink_d;
  logic      sel_q;
  logic      running_q;
  logic      sec_inc, min_inc;
  logic      sec_wrap;
  logic      unused_min_wrap;
  logic      in_run, in_adj;

  assign in_run = (state_q == ST_RUN);
  assign in_adj = (state_q == ST_ADJUST);

  // Minutes advance on a seconds carry in RUN only; adjust never carries.
  assign sec_inc = (in_run && tick_1hz) || (in_adj && tick_2hz && !sel);
  assign min_inc = (in_run && tick_1hz && sec_wrap) || (in_adj && tick_2hz && sel);

  mod_counter #(.MAX(MAX_SEC)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_p),
    .inc   (sec_inc),
    .value (sec),
    .wrap  (sec_wrap)
  );

  mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_p),
    .inc   (min_inc),
    .value (min),
    .wrap  (unused_min_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = ST_ADJUST;
    end else if (in_adj) begin
      state_d = ST_PAUSE;
    end else if (pause_p) begin
      state_d = in_run ? ST_PAUSE : ST_RUN;
    end
  end

  // Held at 0 outside ADJUST so entry always starts visible; a select
  // change restarts the phase visible as well.
  always_comb begin
    blink_d = blink_q;
    if (!in_adj || (sel != sel_q)) begin
      blink_d = 1'b0;
    end else if (tick_2hz) begin
      blink_d = !blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PAUSE;
      blink_q   <= 1'b0;
      sel_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      blink_q   <= blink_d;
      sel_q     <= sel;
      running_q <= (state_d == ST_RUN);
    end
  end

  // Blank select uses the registered sel so it moves on the same edge
  // that forces the blink phase back to visible.
  assign blank_min = in_adj && sel_q && blink_q;
  assign blank_sec = in_adj && !sel_q && blink_q;
  assign running   = running_q;

endmodule
